// File: rtl/fir_ram_coef_loader.sv
// Streams coefficients into the FIR coefficient RAM write port; FIR_COEF_LOADER_CHECKSUM_EN adds a running checksum.
// Latency: an accepted beat drives coef_we_o/addr/data one cycle later; done_o coincides with the final write.
// Backpressure: s_ready_o is high only while loading; stream gaps (s_valid_i low) are waited out indefinitely.
module fir_ram_coef_loader #(
    parameter int COEF_WIDTH  = 16,
    parameter int COEF_AWIDTH = 9
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [COEF_AWIDTH:0]              load_len_i,
    input  logic                              abort_i,
    input  logic                              s_valid_i,
    input  logic [COEF_WIDTH-1:0]             s_data_i,
    input  logic                              s_last_i,
    output logic                              s_ready_o,
    output logic                              coef_we_o,
    output logic [COEF_AWIDTH-1:0]            coef_addr_o,
    output logic [COEF_WIDTH-1:0]             coef_data_o,
    output logic                              fir_hold_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              err_o,
    output logic [COEF_WIDTH+COEF_AWIDTH-1:0] checksum_o
);
    localparam int CSUM_WIDTH = COEF_WIDTH + COEF_AWIDTH;
    localparam int COEF_NUM   = 2 ** COEF_AWIDTH;
    localparam logic [COEF_AWIDTH:0] COEF_NUM_W = (COEF_AWIDTH+1)'(COEF_NUM);
    localparam logic [COEF_AWIDTH:0] ONE        = (COEF_AWIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t               state;
    logic [COEF_AWIDTH:0] cnt_q;
    logic [COEF_AWIDTH:0] last_q;
    logic                 len_ok;
    logic                 start_ok;
    logic                 xfer;
    logic                 final_beat;

    assign len_ok     = (load_len_i != '0) && (load_len_i <= COEF_NUM_W);
    assign start_ok   = (state == IDLE) && start_i && len_ok;
    // Abort wins over a beat presented in the same cycle.
    assign xfer       = (state == LOAD) && s_valid_i && !abort_i;
    assign final_beat = (cnt_q == last_q) || s_last_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            s_ready_o   <= 1'b0;
            coef_we_o   <= 1'b0;
            coef_addr_o <= '0;
            coef_data_o <= '0;
            fir_hold_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            coef_we_o <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state      <= LOAD;
                        cnt_q      <= '0;
                        last_q     <= load_len_i - ONE;
                        s_ready_o  <= 1'b1;
                        busy_o     <= 1'b1;
                        fir_hold_o <= 1'b1;
                    end else if (start_i) begin
                        err_o <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        state     <= DONE;
                        s_ready_o <= 1'b0;
                        done_o    <= 1'b1;
                        err_o     <= 1'b1;
                    end else if (xfer) begin
                        coef_we_o   <= 1'b1;
                        coef_addr_o <= cnt_q[COEF_AWIDTH-1:0];
                        coef_data_o <= s_data_i;
                        cnt_q       <= cnt_q + ONE;
                        // Clean end only when the length and the frame marker agree.
                        if (final_beat) begin
                            state     <= DONE;
                            s_ready_o <= 1'b0;
                            done_o    <= 1'b1;
                            err_o     <= !(s_last_i && (cnt_q == last_q));
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy_o     <= 1'b0;
                    fir_hold_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FIR_COEF_LOADER_CHECKSUM_EN
    logic [CSUM_WIDTH-1:0] csum_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (xfer) begin
            csum_q <= csum_q + {{COEF_AWIDTH{s_data_i[COEF_WIDTH-1]}}, s_data_i};
        end
    end

    assign checksum_o = csum_q;
`else
    assign checksum_o = {CSUM_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_fir_ram_coef_loader.sv
// Bench for fir_ram_coef_loader: vector table, reset-in-load sequence, then randomized loads against a model.
module tb_fir_ram_coef_loader;
    localparam int CW  = 16;
    localparam int AW  = 9;
    localparam int NUM = 512;
    localparam int SW  = CW + AW;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW:0]   load_len_i;
    logic          abort_i;
    logic          s_valid_i;
    logic [CW-1:0] s_data_i;
    logic          s_last_i;
    logic          s_ready_o;
    logic          coef_we_o;
    logic [AW-1:0] coef_addr_o;
    logic [CW-1:0] coef_data_o;
    logic          fir_hold_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [SW-1:0] checksum_o;

    fir_ram_coef_loader #(.COEF_WIDTH(CW), .COEF_AWIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .load_len_i(load_len_i),
        .abort_i(abort_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .s_ready_o(s_ready_o), .coef_we_o(coef_we_o), .coef_addr_o(coef_addr_o),
        .coef_data_o(coef_data_o), .fir_hold_o(fir_hold_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .checksum_o(checksum_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [CW-1:0] dat [0:1023];
    logic [AW-1:0] wr_addr_q [$];
    logic [CW-1:0] wr_data_q [$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int hold_bad = 0;

    // Passive observer, sampling mid-cycle.
    always @(negedge clk) begin
        if (rst_i === 1'b0) begin
            if (coef_we_o === 1'b1) begin
                wr_addr_q.push_back(coef_addr_o);
                wr_data_q.push_back(coef_data_o);
            end
            if (done_o === 1'b1) done_cnt++;
            if (err_o === 1'b1) err_cnt++;
            if ((fir_hold_o !== busy_o) || (coef_we_o && !fir_hold_o) || (done_o && s_ready_o))
                hold_bad++;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: which beats land in RAM, whether the load ends in error, and the checksum.
    function automatic void model(input int len, input int last_idx, input int abort_idx,
                                  output int nwr, output bit err, output int cs);
        int stop;
        logic [SW-1:0] s;
        if (len < 1 || len > NUM) begin
            nwr = 0; err = 1'b1; cs = -1;
            return;
        end
        stop = len - 1;
        if (last_idx >= 0 && last_idx < stop) stop = last_idx;
        if (abort_idx >= 0 && abort_idx <= stop) begin
            nwr = abort_idx; err = 1'b1;
        end else begin
            nwr = stop + 1; err = (last_idx != len - 1);
        end
        s = '0;
        for (int i = 0; i < nwr; i++) s = s + {{AW{dat[i][CW-1]}}, dat[i]};
        cs = int'(s);
    endfunction

    // gmode: 0 = back-to-back, 1 = valid toggling, 2 = random gaps. Entered and left #1 after a posedge.
    task automatic run_case(input int len, input int last_idx, input int abort_idx, input int gmode,
                            input bit acc, input int exp_wr, input bit exp_err, input int exp_cs);
        int beat, cyc, bad, w0, d0, e0, h0, nwr;
        logic v;
        w0 = wr_addr_q.size(); d0 = done_cnt; e0 = err_cnt; h0 = hold_bad;
        start_i = 1'b1; load_len_i = len[AW:0];
        @(posedge clk); #1;
        start_i = 1'b0;
        if (acc) begin
            check("start_busy", busy_o, 1);
            check("start_hold", fir_hold_o, 1);
            check("start_ready", s_ready_o, 1);
            check("start_csum_clear", checksum_o, 0);
            beat = 0; cyc = 0; v = 1'b0;
            while (s_ready_o === 1'b1 && cyc < 4000) begin
                case (gmode)
                    0:       v = 1'b1;
                    1:       v = ~v;
                    default: v = 1'($urandom_range(0, 1));
                endcase
                s_valid_i = v;
                s_data_i  = dat[beat % 1024];
                s_last_i  = (beat == last_idx);
                abort_i   = (beat == abort_idx);
                @(posedge clk);
                if (v && !abort_i) beat++;
                #1;
                s_valid_i = 1'b0; s_last_i = 1'b0; abort_i = 1'b0;
                cyc++;
            end
            check("load_cycle_budget", cyc < 4000, 1);
        end else begin
            check("reject_busy", busy_o, 0);
            check("reject_err_pulse", err_o, 1);
        end
        repeat (3) begin @(posedge clk); #1; end
        nwr = wr_addr_q.size() - w0;
        check("write_count", nwr, exp_wr);
        bad = -1;
        for (int i = 0; i < nwr && i < exp_wr; i++)
            if (bad < 0 && (wr_addr_q[w0+i] !== i[AW-1:0] || wr_data_q[w0+i] !== dat[i])) bad = i;
        check("write_first_bad_index", bad, -1);
        check("done_pulses", done_cnt - d0, acc ? 1 : 0);
        check("err_pulses", err_cnt - e0, exp_err ? 1 : 0);
        check("hold_busy_protocol", hold_bad - h0, 0);
        check("end_busy", busy_o, 0);
        check("end_ready", s_ready_o, 0);
        if (exp_cs >= 0) check("checksum", checksum_o, CSUM_EN ? exp_cs : 0);
    endtask

    typedef struct {
        int len;
        int last_idx;
        int abort_idx;
        int gmode;
        bit acc;
        int exp_wr;
        bit exp_err;
        int exp_cs;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, last_idx, abort_idx, nwr, cs;
        bit err, acc;

        //         len  last  abort gm acc wr   err cs
        tbl[0] = '{4,   3,    -1,   0, 1,  4,   0,  10};
        tbl[1] = '{3,   1,    -1,   0, 1,  2,   1,  3};
        tbl[2] = '{0,   -1,   -1,   0, 0,  0,   1,  -1};
        tbl[3] = '{513, -1,   -1,   0, 0,  0,   1,  -1};
        tbl[4] = '{512, 511,  -1,   1, 1,  512, 0,  131328};
        tbl[5] = '{8,   7,    1,    0, 1,  1,   1,  1};
        tbl[6] = '{5,   4,    -1,   0, 1,  5,   0,  15};
        tbl[7] = '{1,   0,    -1,   0, 1,  1,   0,  1};
        tbl[8] = '{2,   -1,   -1,   0, 1,  2,   1,  3};
        tbl[9] = '{6,   4,    -1,   1, 1,  5,   1,  15};
        for (int i = 0; i < 1024; i++) dat[i] = CW'(i + 1);

        rst_i = 1'b1; start_i = 1'b0; load_len_i = '0; abort_i = 1'b0;
        s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0;
        #1;
        check("rst_ready", s_ready_o, 0);
        check("rst_we", coef_we_o, 0);
        check("rst_addr", coef_addr_o, 0);
        check("rst_data", coef_data_o, 0);
        check("rst_hold", fir_hold_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_checksum", checksum_o, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 10; t++)
            run_case(tbl[t].len, tbl[t].last_idx, tbl[t].abort_idx, tbl[t].gmode,
                     tbl[t].acc, tbl[t].exp_wr, tbl[t].exp_err, tbl[t].exp_cs);

        // Reset lands between edges while writes are streaming.
        start_i = 1'b1; load_len_i = 10'd8;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) begin
            s_valid_i = 1'b1; s_data_i = 16'h55AA;
            @(posedge clk); #1;
        end
        check("pre_reset_we", coef_we_o, 1);
        #3;
        rst_i = 1'b1;
        #1;
        check("midrst_ready", s_ready_o, 0);
        check("midrst_we", coef_we_o, 0);
        check("midrst_addr", coef_addr_o, 0);
        check("midrst_data", coef_data_o, 0);
        check("midrst_hold", fir_hold_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_err", err_o, 0);
        check("midrst_checksum", checksum_o, 0);
        s_valid_i = 1'b0; s_data_i = '0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        run_case(4, 3, -1, 0, 1, 4, 0, 10);

        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 64; i++) dat[i] = CW'($urandom);
            if ($urandom_range(0, 9) == 0)
                len = $urandom_range(0, 1) ? 0 : 513 + int'($urandom_range(0, 510));
            else
                len = $urandom_range(1, 40);
            acc = (len >= 1 && len <= NUM);
            last_idx = -1; abort_idx = -1;
            if (acc) begin
                if ($urandom_range(0, 2) != 0)
                    last_idx = $urandom_range(0, 1) ? len - 1 : int'($urandom_range(0, len - 1));
                if ($urandom_range(0, 3) == 0)
                    abort_idx = $urandom_range(0, len - 1);
            end
            model(len, last_idx, abort_idx, nwr, err, cs);
            run_case(len, last_idx, abort_idx, 2, acc, nwr, err, cs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fir_ram_coef_loader.md
FIR_RAM_COEF_LOADER -- requirements
Module: fir_ram_coef_loader

Interface
REQ-001 Parameter COEF_WIDTH, default 16, coefficient word width in bits.
REQ-002 Parameter COEF_AWIDTH, default 9, coefficient address width; COEF_NUM = 2**COEF_AWIDTH.
REQ-003 clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 load_len_i  input  COEF_AWIDTH+1  number of coefficients to load, sampled with start_i.
REQ-007 abort_i  input  1  cancels a load in progress.
REQ-008 s_valid_i  input  1  stream coefficient valid.
REQ-009 s_data_i  input  COEF_WIDTH  stream coefficient value.
REQ-010 s_last_i  input  1  marks the final stream beat.
REQ-011 s_ready_o  output  1  loader accepts a beat.
REQ-012 coef_we_o  output  1  write strobe to the coefficient RAM write port.
REQ-013 coef_addr_o  output  COEF_AWIDTH  write address.
REQ-014 coef_data_o  output  COEF_WIDTH  write data.
REQ-015 fir_hold_o  output  1  high while the RAM write port owns the address bus; the FIR datapath stalls.
REQ-016 busy_o  output  1  high in any state other than IDLE.
REQ-017 done_o  output  1  one-cycle pulse at load completion or abort.
REQ-018 err_o  output  1  one-cycle pulse, coincident with done_o or with a rejected start.
REQ-019 checksum_o  output  COEF_WIDTH+COEF_AWIDTH  sum of written coefficients (see Configuration).

Function
REQ-020 FSM states: IDLE, LOAD, DONE.
REQ-021 IDLE: s_ready_o=0; start_i with 1 <= load_len_i <= COEF_NUM latches length, clears address counter to 0, moves to LOAD.
REQ-022 IDLE: start_i with load_len_i=0 or >COEF_NUM -> err_o pulse next cycle, no done_o, stay IDLE.
REQ-023 LOAD: s_ready_o=1; a beat transfers when s_valid_i & s_ready_o.
REQ-024 Each transfer: next cycle coef_we_o=1, coef_addr_o=counter, coef_data_o=s_data_i (latency 1); counter increments; otherwise coef_we_o=0, addr/data hold.
REQ-025 Transfer with counter = len-1: s_ready_o deasserts next cycle, FSM -> DONE; err flagged if s_last_i=0 on that beat.
REQ-026 Transfer with s_last_i=1 and counter < len-1: beat written, FSM -> DONE, err flagged (short frame).
REQ-027 s_valid_i gaps in LOAD: wait indefinitely, no writes.
REQ-028 Counter never wraps: len=COEF_NUM writes addresses 0..COEF_NUM-1 then stops.
REQ-029 DONE: lasts one cycle; done_o=1, err_o=flag; last write completes this cycle; then IDLE.
REQ-030 fir_hold_o = 1 in LOAD and DONE, 0 in IDLE.
REQ-031 abort_i in LOAD (priority over a simultaneous transfer, which is not accepted) -> DONE with err flagged; already-written words remain.
REQ-032 start_i and abort_i ignored outside their stated states.

Reset
REQ-033 Asserting rst_i at any time, including mid-LOAD, forces IDLE immediately, zero counter and flags.
REQ-034 Reset values: s_ready_o=0, coef_we_o=0, coef_addr_o=0, coef_data_o=0, fir_hold_o=0, busy_o=0, done_o=0, err_o=0, checksum_o=0.

Configuration
REQ-035 Macro FIR_COEF_LOADER_CHECKSUM_EN defined: checksum_o cleared on accepted start, adds each written coefficient (sign-extended, modulo 2**(COEF_WIDTH+COEF_AWIDTH)), stable from DONE until next accepted start.
REQ-036 Macro undefined: no accumulator logic; checksum_o constant 0.

Verification
REQ-037 start len=4, beats 0x0001,0x0002,0x0003,0x0004(last) back-to-back -> writes addr0..3 one cycle after each beat, done_o=1 err_o=0, fir_hold_o high from start+1 to DONE; checksum=0x000A if enabled.
REQ-038 start len=3, beat 2 with s_last_i=1 -> writes addr0..1, done_o=1 err_o=1, s_ready_o=0 after.
REQ-039 start len=0 and len=513 (COEF_AWIDTH=9) -> err_o pulse, busy_o stays 0, no writes.
REQ-040 start len=512, s_valid_i toggling 1/0 -> exactly 512 writes addr 0..511, no wrap, done_o once.
REQ-041 abort_i coincident with valid beat 2 of len=8 -> beat not written, done_o=1 err_o=1, next start accepted.
REQ-042 rst_i asserted mid-LOAD between clock edges -> all outputs 0 immediately; new load after release starts at addr0.
